// File: rtl/seg7_pkg.sv
// seg7_pkg: segment constants, FSM state type and hex decoder for seg7_reader
package seg7_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0 = 7'h3F, SEG_1 = 7'h06, SEG_2 = 7'h5B, SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66, SEG_5 = 7'h6D, SEG_6 = 7'h7D, SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F, SEG_9 = 7'h6F, SEG_A = 7'h77, SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39, SEG_D = 7'h5E, SEG_E = 7'h79, SEG_F = 7'h71;

    typedef enum logic {SETTLE, STABLE} state_t;

    // Returns {is_hex, digit}; is_hex is 0 for blank and for non-hex patterns.
    function automatic logic [4:0] hex_decode(input logic [6:0] seg);
        case (seg)
            SEG_0: return 5'h10;
            SEG_1: return 5'h11;
            SEG_2: return 5'h12;
            SEG_3: return 5'h13;
            SEG_4: return 5'h14;
            SEG_5: return 5'h15;
            SEG_6: return 5'h16;
            SEG_7: return 5'h17;
            SEG_8: return 5'h18;
            SEG_9: return 5'h19;
            SEG_A: return 5'h1A;
            SEG_B: return 5'h1B;
            SEG_C: return 5'h1C;
            SEG_D: return 5'h1D;
            SEG_E: return 5'h1E;
            SEG_F: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction
endpackage

// File: rtl/seg7_fifo.sv
// seg7_fifo: power-of-two FIFO with occupancy count
//   push/din: write request, dropped when full unless pop in same cycle
//   pop: read request; dout: head (0 when empty); full/empty/count: status
module seg7_fifo import seg7_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic wr_en, rd_en;

    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign rd_en = pop && !empty;
    // A pop frees the slot in the same cycle, so a push at full still lands.
    assign wr_en = push && (!full || rd_en);
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr] <= din;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_en);
            rd_ptr <= rd_ptr + AW'(rd_en);
            count  <= count + CW'(wr_en) - CW'(rd_en);
        end
endmodule

// File: rtl/seg7_reader.sv
// seg7_reader: debounces a seven-segment pattern, decodes hex digits into a FIFO
//   seg_in: async pattern (bit0=a..bit6=g, bit7=dp); digit_o/dp_o/valid_o/ready_i: FIFO head
//   invalid_o/overflow_o: sticky flags, cleared by clear_i
//   SEG7_READER_DP_EN: when defined, dp is compared and stored; otherwise dp_o=0
module seg7_reader import seg7_pkg::*; #(
    parameter int STABLE_CYCLES = 4,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_in,
    output logic [3:0] digit_o,
    output logic       dp_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       invalid_o,
    output logic       overflow_o,
    input  logic       clear_i
);
`ifdef SEG7_READER_DP_EN
    localparam int PW = 8;
    localparam int FW = 5;
`else
    localparam int PW = 7;
    localparam int FW = 4;
`endif
    localparam logic [7:0] SC = 8'(STABLE_CYCLES);

    logic [PW-1:0] s1, s2, cand, last;
    logic [7:0] cnt;
    state_t state;
    logic [4:0] dec;
    logic [FW-1:0] din, dout;
    logic acc, blank, push, pop, full, empty, inv_set, ovf_set;
    logic [$clog2(DEPTH):0] count;
    logic unused;

    assign dec     = hex_decode(cand[6:0]);
    assign blank   = cand[6:0] == SEG_BLANK;
    assign acc     = state == SETTLE && s2 == cand && cnt == SC;
    assign push    = acc && dec[4] && cand != last;
    assign inv_set = acc && !blank && !dec[4];
    assign valid_o = !empty;
    assign pop     = valid_o && ready_i;
    assign ovf_set = push && full && !pop;
    assign digit_o = dout[3:0];
`ifdef SEG7_READER_DP_EN
    assign din    = {cand[7], dec[3:0]};
    assign dp_o   = dout[4];
    assign unused = ^count;
`else
    assign din    = dec[3:0];
    assign dp_o   = 1'b0;
    assign unused = ^{seg_in[7], count};
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1         <= '0;
            s2         <= '0;
            cand       <= '0;
            last       <= '0;
            cnt        <= '0;
            state      <= SETTLE;
            invalid_o  <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            s1 <= seg_in[PW-1:0];
            s2 <= s1;
            if (s2 != cand) begin
                state <= SETTLE;
                cand  <= s2;
                cnt   <= 8'd1;
            end else if (state == SETTLE) begin
                if (cnt == SC) state <= STABLE;
                else cnt <= cnt + 8'd1;
            end
            // Blank forgets the last digit so a repeat after a blank is re-emitted.
            if (acc && blank) last <= '0;
            else if (push) last <= cand;
            invalid_o  <= inv_set ? 1'b1 : clear_i ? 1'b0 : invalid_o;
            overflow_o <= ovf_set ? 1'b1 : clear_i ? 1'b0 : overflow_o;
        end

    seg7_fifo #(.DEPTH(DEPTH), .WIDTH(FW)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .din(din),
        .dout(dout),
        .full(full),
        .empty(empty),
        .count(count)
    );
endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: scoreboard bench for seg7_reader (STABLE_CYCLES=4, DEPTH=4)
module tb_seg7_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] seg_in = 8'h00;
    logic [3:0] digit_o;
    logic dp_o, valid_o, invalid_o, overflow_o;
    logic ready_i = 1'b1;
    logic clear_i = 1'b0;

    int errors = 0;
    int checks = 0;
    int pops = 0;
    int cyc = 0;
    logic [4:0] exp_q[$];

    seg7_reader #(.STABLE_CYCLES(4), .DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .seg_in(seg_in),
        .digit_o(digit_o),
        .dp_o(dp_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .invalid_o(invalid_o),
        .overflow_o(overflow_o),
        .clear_i(clear_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input logic [7:0] p, input int n);
        seg_in = p;
        step(n);
    endtask

    // Monitor: every accepted head is compared with the oldest expected entry.
    always @(negedge clk)
        if (!rst && valid_o && ready_i) begin
            pops++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pop: got %0h expected none", {dp_o, digit_o});
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                if ({dp_o, digit_o} != e) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", {dp_o, digit_o}, e);
                end
            end
        end

    initial begin
        int n, lat;
        step(2);
        chk("rst_valid", valid_o, 0);
        chk("rst_digit", digit_o, 0);
        chk("rst_dp", dp_o, 0);
        chk("rst_invalid", invalid_o, 0);
        chk("rst_overflow", overflow_o, 0);
        rst = 1'b0;
        step(10);

        // Single digit: one pulse at cycle 7 after the change.
        exp_q.push_back(5'h01);
        seg_in = 8'h06;
        n = 0;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (valid_o) begin
                n++;
                if (n == 1) lat = i;
            end
        end
        chk("one_pulse", n, 1);
        chk("latency", lat, 7);

        // Bouncing between 1 and 2 never settles; only the final 2 is emitted.
        exp_q.push_back(5'h02);
        for (int i = 0; i < 5; i++) begin
            hold(8'h06, 2);
            hold(8'h5B, 2);
        end
        hold(8'h5B, 10);
        chk("bounce_pops", pops, 2);

        // Repeat of 0 is suppressed until a blank intervenes.
        exp_q.push_back(5'h00);
        exp_q.push_back(5'h00);
        hold(8'h3F, 8);
        hold(8'h3F, 8);
        hold(8'h00, 8);
        hold(8'h3F, 8);
        chk("blank_pops", pops, 4);

        // Stalled consumer: 1..4 fill the FIFO, 5 and 6 overflow.
        ready_i = 1'b0;
        hold(8'h06, 8);
        hold(8'h5B, 8);
        hold(8'h4F, 8);
        hold(8'h66, 8);
        chk("full_no_overflow", overflow_o, 0);
        hold(8'h6D, 8);
        hold(8'h7D, 8);
        for (int d = 1; d <= 4; d++) exp_q.push_back(5'(d));
        chk("stall_valid", valid_o, 1);
        chk("stall_head", digit_o, 1);
        chk("overflow_set", overflow_o, 1);
        step(3);
        chk("stall_head_stable", digit_o, 1);
        ready_i = 1'b1;
        step(6);
        chk("drain_pops", pops, 8);
        chk("drain_empty", valid_o, 0);
        chk("overflow_sticky", overflow_o, 1);
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
        chk("overflow_clear", overflow_o, 0);

        // Non-hex pattern flags invalid and emits nothing.
        hold(8'h49, 10);
        chk("invalid_set", invalid_o, 1);
        chk("invalid_no_pop", pops, 8);
        clear_i = 1'b1;
        step(1);
        clear_i = 1'b0;
        chk("invalid_clear", invalid_o, 0);

        // Reset mid-settle of 4 discards everything.
        hold(8'h66, 4);
        rst = 1'b1;
        seg_in = 8'h00;
        #1;
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_digit", digit_o, 0);
        chk("mid_rst_invalid", invalid_o, 0);
        chk("mid_rst_overflow", overflow_o, 0);
        step(2);
        rst = 1'b0;
        step(14);
        chk("after_rst_pops", pops, 8);

`ifdef SEG7_READER_DP_EN
        exp_q.push_back(5'h01);
        exp_q.push_back(5'h11);
        hold(8'h06, 10);
        hold(8'h86, 10);
        chk("dp_pops", pops, 10);
`endif
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical samples required before a pattern is accepted (legal range 2..255).
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of output FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port seg_in, input, 8 bits: seven-segment pattern, bit0=a .. bit6=g, bit7=dp, active-high, asynchronous to clk.
REQ-006 SHALL have port digit_o, output, 4 bits: decoded hex value at the FIFO head.
REQ-007 SHALL have port dp_o, output, 1 bit: decimal point stored with the FIFO head; constant 0 when SEG7_READER_DP_EN is undefined.
REQ-008 SHALL have port valid_o, output, 1 bit: FIFO head is valid.
REQ-009 SHALL have port ready_i, input, 1 bit: consumer accepts the head.
REQ-010 SHALL have port invalid_o, output, 1 bit: sticky flag, set when a non-hex, non-blank pattern is accepted.
REQ-011 SHALL have port overflow_o, output, 1 bit: sticky flag, set when a decoded digit is dropped because the FIFO is full.
REQ-012 SHALL have port clear_i, input, 1 bit: synchronous clear of both sticky flags.

Function
REQ-013 SHALL pass seg_in through a 2-flop synchronizer; all later logic uses the synchronized value only.
REQ-014 SHALL implement FSM states SETTLE and STABLE, plus a counter cnt and a register cand.
REQ-015 In SETTLE: if sample==cand, cnt SHALL increment; otherwise cand SHALL take the sample and cnt SHALL reload to 1.
REQ-016 When cnt reaches STABLE_CYCLES, the FSM SHALL go to STABLE and, in that same cycle, perform the accept action of REQ-018.
REQ-017 In STABLE: any sample!=cand SHALL return the FSM to SETTLE with cand=sample and cnt=1; nothing further is emitted while the pattern holds.
REQ-018 Accept action:
- blank pattern (a..g all 0): SHALL emit nothing and clear the last-emitted register, so a repeat digit after a blank is emitted again;
- hex pattern equal to the last emitted pattern: SHALL emit nothing;
- other hex pattern: SHALL push {dp, digit} and update the last-emitted register;
- any other pattern: SHALL set invalid_o and push nothing.
REQ-019 SHALL decode the hex table (a..g, hex) as: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
REQ-020 Latency SHALL be exactly 2 (sync) + STABLE_CYCLES + 1 cycles from a seg_in change to valid_o rising, with the FIFO empty.
REQ-021 Handshake: a pop SHALL occur on a cycle with valid_o && ready_i; digit_o/dp_o SHALL be stable while valid_o && !ready_i.
REQ-022 SHALL treat push and pop in the same cycle as legal at any occupancy, including full (push accepted, no overflow).
REQ-023 On a push to a full FIFO without a simultaneous pop, SHALL drop the entry and set overflow_o.
REQ-024 SHALL wrap the FIFO pointers modulo DEPTH; full/empty SHALL derive from an occupancy count of width clog2(DEPTH)+1.
REQ-025 When clear_i is asserted in the same cycle as a set event, the set SHALL win.

Reset
REQ-026 On rst: FSM=SETTLE, cnt=0, cand=0, synchronizer=0, last-emitted=blank, FIFO empty, valid_o=0, digit_o=0, dp_o=0, invalid_o=0, overflow_o=0.
REQ-027 Reset asserted mid-settle or mid-handshake SHALL discard all state; no partial entry SHALL survive.

Configuration
REQ-028 With SEG7_READER_DP_EN defined: dp SHALL take part in the stability compare and the repeat compare, and SHALL be stored in the FIFO (width 5).
REQ-029 Without SEG7_READER_DP_EN: seg_in[7] SHALL be ignored, FIFO width SHALL be 4, and dp_o SHALL be tied to 0.

Structure
REQ-030 Package seg7_pkg SHALL hold the segment constants for 0..F, SEG_BLANK, the FSM state enum, and the hex-decode function.
REQ-031 The FIFO SHALL be sub-module seg7_fifo (parameters DEPTH and WIDTH, with a push/pop/full/empty/count interface).

Verification
REQ-032 seg_in=0x06 held 10 cycles, ready_i=1 -> exactly one pulse, valid_o=1 with digit_o=1, at cycle 7 after the change (STABLE_CYCLES=4).
REQ-033 seg_in toggling 0x06/0x5B every 2 cycles for 20 cycles, then holding 0x5B -> a single emission of digit 2 only.
REQ-034 Sequence 0x3F, 0x3F, 0x00, 0x3F (each held 8 cycles) -> two emissions of digit 0.
REQ-035 ready_i=0, six distinct digits 1..6 -> FIFO holds 1..4 and overflow_o=1; then ready_i=1 -> pops 1,2,3,4 in order; clear_i -> overflow_o=0.
REQ-036 seg_in=0x49 held stable -> invalid_o=1 and valid_o stays 0; rst asserted mid-settle of 0x66 -> all outputs 0 and no digit emitted afterwards.
REQ-037 With SEG7_READER_DP_EN defined: 0x06 then 0x86 -> two emissions, dp_o=0 then dp_o=1.
